// File: rtl/mem_access.sv
// MEM pipeline stage: serialises byte/halfword/word loads and stores onto a
// byte-wide RAM port (little-endian) and stalls the pipeline until done.
module mem_access #(
  parameter int RAM_ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               memaddr_i,
  input  logic                      memwr_i,
  input  logic [1:0]                memcnf_i,
  input  logic                      memsigned_i,
  input  logic [31:0]               wdata_i,
  input  logic [4:0]                wd_i,
  input  logic                      wreg_i,
  output logic [4:0]                wd_o,
  output logic                      wreg_o,
  output logic [31:0]               wdata_o,
  output logic                      mem_stall,
  output logic [RAM_ADDR_WIDTH-1:0] ram_a_o,
  output logic [7:0]                ram_dout_o,
  output logic                      ram_wr_o,
  input  logic [7:0]                ram_din_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [31:0] data;

  logic [2:0]  n;
  logic [2:0]  issue_idx;
  logic [31:0] issue_addr;
  logic [7:0]  issue_byte;
  logic [31:0] load_result;

  always_comb begin
    case (memcnf_i)
      2'd1:    n = 3'd1;
      2'd2:    n = 3'd2;
      2'd3:    n = 3'd4;
      default: n = 3'd0;
    endcase
  end

  // Byte 0 goes out from IDLE; later bytes are indexed by the transfer counter.
  assign issue_idx  = (state == BUSY) ? cnt : 3'd0;
  assign issue_addr = memaddr_i + {29'd0, issue_idx};

  always_comb begin
    case (issue_idx[1:0])
      2'd0:    issue_byte = wdata_i[7:0];
      2'd1:    issue_byte = wdata_i[15:8];
      2'd2:    issue_byte = wdata_i[23:16];
      default: issue_byte = wdata_i[31:24];
    endcase
  end

  always_comb begin
    case (memcnf_i)
      2'd1:    load_result = {{24{memsigned_i & data[7]}}, data[7:0]};
      2'd2:    load_result = {{16{memsigned_i & data[15]}}, data[15:0]};
      default: load_result = data;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
      data  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (memcnf_i != 2'd0) begin
            data <= 32'd0;
            if (memwr_i && n == 3'd1) begin
              state <= DONE;
              cnt   <= 3'd0;
            end else begin
              state <= BUSY;
              cnt   <= 3'd1;
            end
          end
        end
        BUSY: begin
          cnt <= cnt + 3'd1;
          if (memwr_i) begin
            if (cnt == n - 3'd1) state <= DONE;
          end else begin
            // RAM read data lags the address by one cycle, hence byte cnt-1.
            case (cnt)
              3'd1:    data[7:0]   <= ram_din_i;
              3'd2:    data[15:8]  <= ram_din_i;
              3'd3:    data[23:16] <= ram_din_i;
              3'd4:    data[31:24] <= ram_din_i;
              default: data        <= data;
            endcase
            if (cnt == n) state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= 3'd0;
        end
        default: begin
          state <= IDLE;
          cnt   <= 3'd0;
        end
      endcase
    end
  end

  always_comb begin
    wd_o       = 5'd0;
    wreg_o     = 1'b0;
    wdata_o    = 32'd0;
    mem_stall  = 1'b0;
    ram_a_o    = '0;
    ram_dout_o = 8'd0;
    ram_wr_o   = 1'b0;
    if (!rst) begin
      wd_o    = wd_i;
      wdata_o = wdata_i;
      case (state)
        IDLE: begin
          if (memcnf_i == 2'd0) begin
            wreg_o = wreg_i;
          end else begin
            mem_stall = 1'b1;
            ram_a_o   = issue_addr[RAM_ADDR_WIDTH-1:0];
            if (memwr_i) begin
              ram_wr_o   = 1'b1;
              ram_dout_o = issue_byte;
            end
          end
        end
        BUSY: begin
          mem_stall = 1'b1;
          if (memwr_i) begin
            ram_a_o    = issue_addr[RAM_ADDR_WIDTH-1:0];
            ram_wr_o   = 1'b1;
            ram_dout_o = issue_byte;
          end else if (cnt < n) begin
            ram_a_o = issue_addr[RAM_ADDR_WIDTH-1:0];
          end
        end
        DONE: begin
          if (!memwr_i) begin
            wdata_o = load_result;
            wreg_o  = wreg_i;
          end
        end
        default: begin
          mem_stall = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: byte RAM model, reference memory image and
// directed plus random load/store/ALU traffic.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] memaddr_i;
  logic        memwr_i;
  logic [1:0]  memcnf_i;
  logic        memsigned_i;
  logic [31:0] wdata_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        mem_stall;
  logic [31:0] ram_a_o;
  logic [7:0]  ram_dout_o;
  logic        ram_wr_o;
  logic [7:0]  ram_din_i;

  logic        ram_init;
  logic [7:0]  mem     [0:4095];
  logic [7:0]  ref_mem [0:4095];

  int checks = 0;
  int errors = 0;

  mem_access dut (
    .clk(clk), .rst(rst), .memaddr_i(memaddr_i), .memwr_i(memwr_i),
    .memcnf_i(memcnf_i), .memsigned_i(memsigned_i), .wdata_i(wdata_i),
    .wd_i(wd_i), .wreg_i(wreg_i), .wd_o(wd_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .mem_stall(mem_stall), .ram_a_o(ram_a_o),
    .ram_dout_o(ram_dout_o), .ram_wr_o(ram_wr_o), .ram_din_i(ram_din_i)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] seed(int i);
    logic [31:0] x;
    x = 32'(i) * 32'h9E3779B1;
    return x[23:16] ^ x[7:0];
  endfunction

  // 4 KiB RAM aliased on the low address bits, registered read.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= seed(i);
    end else if (ram_wr_o) begin
      mem[ram_a_o[11:0]] <= ram_dout_o;
    end
    ram_din_i <= mem[ram_a_o[11:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one instruction from IDLE through its DONE cycle; entered just after a negedge.
  task automatic run_op(input logic [1:0] cnf, input logic wr, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] wd, input logic wreg, output logic [31:0] res);
    int n;
    int stalls;
    logic [31:0] exp_res;
    logic [31:0] sh;
    logic [31:0] a;
    memcnf_i = cnf; memwr_i = wr; memsigned_i = sgn; memaddr_i = addr;
    wdata_i = data; wd_i = wd; wreg_i = wreg;
    #1;
    if (cnf == 2'd0) begin
      check("alu_wdata", wdata_o, data);
      check("alu_wd", {27'd0, wd_o}, {27'd0, wd});
      check("alu_wreg", {31'd0, wreg_o}, {31'd0, wreg});
      check("alu_stall", {31'd0, mem_stall}, 32'd0);
      check("alu_ram_wr", {31'd0, ram_wr_o}, 32'd0);
      res = wdata_o;
      @(negedge clk);
      $display("op ALU wdata=%h wd=%0d wreg=%0d -> wdata_o=%h", data, wd, wreg, res);
      return;
    end
    n = (cnf == 2'd1) ? 1 : (cnf == 2'd2) ? 2 : 4;
    exp_res = 32'd0;
    for (int k = 0; k < n; k++) begin
      a = addr + 32'(k);
      exp_res = exp_res | ({24'd0, ref_mem[a[11:0]]} << (8 * k));
    end
    if (sgn && n == 1 && exp_res[7])  exp_res = exp_res | 32'hFFFFFF00;
    if (sgn && n == 2 && exp_res[15]) exp_res = exp_res | 32'hFFFF0000;
    stalls = 0;
    for (int i = 0; i < 12 && mem_stall; i++) begin
      a = addr + 32'(i);
      check("stall_wreg", {31'd0, wreg_o}, 32'd0);
      check("stall_wdata", wdata_o, data);
      if (wr) begin
        sh = data >> (8 * i);
        check("st_ram_wr", {31'd0, ram_wr_o}, 32'd1);
        check("st_ram_a", ram_a_o, a);
        check("st_ram_dout", {24'd0, ram_dout_o}, {24'd0, sh[7:0]});
      end else if (i < n) begin
        check("ld_ram_wr", {31'd0, ram_wr_o}, 32'd0);
        check("ld_ram_a", ram_a_o, a);
      end else begin
        check("ld_idle_ram_a", ram_a_o, 32'd0);
      end
      stalls++;
      @(negedge clk);
      #1;
    end
    check("stall_cycles", 32'(stalls), wr ? 32'(n) : 32'(n + 1));
    check("done_stall", {31'd0, mem_stall}, 32'd0);
    check("done_ram_wr", {31'd0, ram_wr_o}, 32'd0);
    check("done_wd", {27'd0, wd_o}, {27'd0, wd});
    check("done_wreg", {31'd0, wreg_o}, wr ? 32'd0 : {31'd0, wreg});
    check("done_wdata", wdata_o, wr ? data : exp_res);
    res = wdata_o;
    if (wr) begin
      for (int k = 0; k < n; k++) begin
        a = addr + 32'(k);
        sh = data >> (8 * k);
        ref_mem[a[11:0]] = sh[7:0];
      end
    end
    $display("op %s n=%0d signed=%0d addr=%h data=%h stalls=%0d -> wdata_o=%h",
             wr ? "ST" : "LD", n, sgn, addr, data, stalls, res);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] d;
    logic [1:0]  cnf;
    logic        wr;
    int          bad;
    rst = 1'b1; ram_init = 1'b1;
    memcnf_i = 2'd3; memwr_i = 1'b1; memsigned_i = 1'b1; memaddr_i = 32'h1234;
    wdata_i = 32'hCAFEF00D; wd_i = 5'd7; wreg_i = 1'b1;
    for (int i = 0; i < 4096; i++) ref_mem[i] = seed(i);
    #1;
    check("rst_wdata", wdata_o, 32'd0);
    check("rst_wd", {27'd0, wd_o}, 32'd0);
    check("rst_wreg", {31'd0, wreg_o}, 32'd0);
    check("rst_stall", {31'd0, mem_stall}, 32'd0);
    check("rst_ram_wr", {31'd0, ram_wr_o}, 32'd0);
    check("rst_ram_a", ram_a_o, 32'd0);
    check("rst_ram_dout", {24'd0, ram_dout_o}, 32'd0);
    $display("reset: outputs held at zero");
    @(negedge clk);
    ram_init = 1'b0;
    rst = 1'b0;

    run_op(2'd0, 1'b0, 1'b0, 32'h0, 32'h12345678, 5'd5, 1'b1, r);
    run_op(2'd3, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 5'd1, 1'b1, r);
    run_op(2'd1, 1'b1, 1'b0, 32'h20, 32'h00000080, 5'd2, 1'b0, r);
    run_op(2'd1, 1'b1, 1'b0, 32'h31, 32'h00000034, 5'd2, 1'b0, r);
    run_op(2'd1, 1'b1, 1'b0, 32'h32, 32'h00000092, 5'd2, 1'b0, r);
    run_op(2'd3, 1'b1, 1'b0, 32'h40, 32'h04030201, 5'd2, 1'b0, r);
    run_op(2'd1, 1'b0, 1'b1, 32'h20, 32'h0, 5'd9, 1'b1, r);
    check("lb_signed", r, 32'hFFFFFF80);
    run_op(2'd1, 1'b0, 1'b0, 32'h20, 32'h0, 5'd9, 1'b1, r);
    check("lbu", r, 32'h00000080);
    run_op(2'd2, 1'b0, 1'b1, 32'h31, 32'h0, 5'd10, 1'b1, r);
    check("lh_misaligned", r, 32'hFFFF9234);
    run_op(2'd3, 1'b0, 1'b0, 32'h40, 32'h0, 5'd11, 1'b1, r);
    check("lw", r, 32'h04030201);
    run_op(2'd3, 1'b0, 1'b0, 32'h100, 32'h0, 5'd12, 1'b1, r);
    check("lw_after_sw", r, 32'hDEADBEEF);
    run_op(2'd1, 1'b1, 1'b0, 32'h10, 32'h000000AA, 5'd3, 1'b1, r);
    run_op(2'd1, 1'b0, 1'b0, 32'h10, 32'h0, 5'd4, 1'b1, r);
    check("sb_then_lbu", r, 32'h000000AA);
    run_op(2'd3, 1'b1, 1'b0, 32'hFFFFFFFE, 32'h89ABCDEF, 5'd3, 1'b0, r);
    run_op(2'd3, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h0, 5'd6, 1'b1, r);
    check("lw_wrap", r, 32'h89ABCDEF);

    // Reset during the second byte of a word store.
    d = {~seed(32'h203), ~seed(32'h202), ~seed(32'h201), 8'h5A};
    memcnf_i = 2'd3; memwr_i = 1'b1; memsigned_i = 1'b0; memaddr_i = 32'h200;
    wdata_i = d; wd_i = 5'd8; wreg_i = 1'b0;
    #1;
    check("rsw_b0_wr", {31'd0, ram_wr_o}, 32'd1);
    check("rsw_b0_a", ram_a_o, 32'h200);
    @(negedge clk);
    #1;
    check("rsw_b1_a", ram_a_o, 32'h201);
    rst = 1'b1;
    #1;
    check("rsw_rst_wr", {31'd0, ram_wr_o}, 32'd0);
    check("rsw_rst_stall", {31'd0, mem_stall}, 32'd0);
    check("rsw_rst_a", ram_a_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ref_mem[12'h200] = d[7:0];
    $display("reset mid-store at 0x201");
    run_op(2'd0, 1'b0, 1'b0, 32'h0, 32'h00000055, 5'd3, 1'b1, r);
    run_op(2'd3, 1'b0, 1'b0, 32'h200, 32'h0, 5'd13, 1'b1, r);

    for (int t = 0; t < 80; t++) begin
      cnf = 2'($urandom_range(0, 3));
      wr  = (cnf != 2'd0) ? 1'($urandom_range(0, 1)) : 1'b0;
      d   = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 63));
      run_op(cnf, wr, 1'($urandom_range(0, 1)), d, $urandom(),
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), r);
    end

    bad = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("ram_image", 32'(bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM stage: consumes the memory request produced by the execute stage (address, load/store, size, signedness, store data) and performs it over the byte-wide RAM port.
- Serialises halfword and word accesses into little-endian byte transfers.
- Assembles and sign/zero-extends load data.
- Holds the pipeline via mem_stall until the access completes; non-memory instructions pass straight through to write-back.

Parameters:
RAM_ADDR_WIDTH, 32, width of ram_a_o; low bits of the byte address are forwarded.

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high (`RstEnable = 1)
memaddr_i  input  32  byte address of the access
memwr_i  input  1  0 = load, 1 = store
memcnf_i  input  2  0 = no memory access, 1 = byte, 2 = halfword, 3 = word
memsigned_i  input  1  1 = sign-extend load result, 0 = zero-extend
wdata_i  input  32  ALU result (non-memory) or store data (store)
wd_i  input  5  destination register
wreg_i  input  1  destination write enable
wd_o  output  5  destination register to write-back
wreg_o  output  1  write enable to write-back
wdata_o  output  32  write-back data
mem_stall  output  1  1 = hold pipeline stages up to and including EX/MEM latch
ram_a_o  output  RAM_ADDR_WIDTH  RAM byte address
ram_dout_o  output  8  RAM write data
ram_wr_o  output  1  1 = write ram_dout_o at ram_a_o this cycle
ram_din_i  input  8  RAM read data, valid one cycle after address presented

Behaviour:
- Reset (asynchronous, immediate): state = IDLE, cnt = 0, data register = 0. All outputs are 0, including ram_wr_o, and stay 0 while rst = 1. Reset mid-access abandons the access; bytes already written stay written.
- n = 1, 2, 4 for memcnf_i = 1, 2, 3. Byte k goes to memaddr_i + k (32-bit add, wraps, truncated to RAM_ADDR_WIDTH).
- Little-endian byte ordering: byte k = data[8k+7:8k]. Misaligned addresses are legal.
- Inputs are held stable by the upstream latch while mem_stall = 1.
- IDLE:
  - memcnf_i = 0: pure pass-through, combinational. wd_o = wd_i, wreg_o = wreg_i, wdata_o = wdata_i, mem_stall = 0, ram_wr_o = 0.
  - memcnf_i != 0: issue byte 0 this cycle (ram_a_o = addr; for stores ram_wr_o = 1 and ram_dout_o = byte 0 of wdata_i). mem_stall = 1, data register cleared.
  - Next state: store with n = 1 -> DONE; otherwise -> BUSY with cnt = 1.
- BUSY, store: issue byte cnt with ram_wr_o = 1 and mem_stall = 1; cnt++. When cnt == n-1 is issued -> DONE.
- BUSY, load:
  - if cnt < n: ram_a_o = addr + cnt, ram_wr_o = 0.
  - Every BUSY cycle captures ram_din_i into byte cnt-1 of the data register; mem_stall = 1; cnt++.
  - The cycle with cnt == n issues no address, captures the last byte, then -> DONE.
- DONE (exactly one cycle):
  - mem_stall = 0, ram_wr_o = 0; the upstream latch advances at this edge.
  - Next state is IDLE unconditionally, so the next instruction is evaluated in IDLE.
- Load result in DONE:
  - byte: bits[7:0], extended from bit 7 when memsigned_i = 1, else zero.
  - halfword: bits[15:0], extended from bit 15.
  - word: as-is.
  - wdata_o = result, wreg_o = wreg_i.
- Store in DONE: wreg_o = 0 (forced for any store in any state), wdata_o = wdata_i.
- Outputs while stalled:
  - wd_o = wd_i, wdata_o = wdata_i.
  - wreg_o = 0 while mem_stall = 1, so write-back never commits a partial result.
- Stall length:
  - store: n cycles stalled.
  - load: n + 1 cycles stalled.
  - back-to-back memory ops: a one-cycle DONE gap between them.
- ram_a_o = 0 and ram_dout_o = 0 whenever no byte is issued.

Test Plan:
- ALU pass-through: memcnf=0, wdata_i=0x12345678, wd=5, wreg=1 -> same cycle wdata_o=0x12345678, wd_o=5, wreg_o=1, mem_stall=0, ram_wr_o=0.
- SW addr=0x100, data=0xDEADBEEF -> 4 stalled cycles writing EF, BE, AD, DE to 0x100..0x103; DONE cycle stall=0, wreg_o=0.
- LB signed addr=0x20, RAM[0x20]=0x80 -> 2 stalled cycles; DONE wdata_o=0xFFFFFF80. Same with memsigned=0 -> 0x00000080.
- LH signed addr=0x31 (misaligned), RAM[0x31]=0x34, RAM[0x32]=0x92 -> 3 stalled cycles; wdata_o=0xFFFF9234. LW at 0x40 of bytes 01 02 03 04 -> 0x04030201 after 5 stalled cycles.
- Back-to-back SB 0x10 (0xAA) then LBU 0x10 -> SB stall 1 cycle, DONE, then LBU stalls 2 cycles and returns 0x000000AA.
- Assert rst during the second byte of SW -> ram_wr_o drops immediately; after release the block is in IDLE, stall=0; remaining bytes are never written.
